vs_spi_responder: RTL and testbench
===================================

// Module: vs_spi_responder
// PURPOSE
//  Codec-side end of the VS1003B-style serial link: SCI command port (XCS) plus SDI data port (XDCS).
//  Decodes SCI register reads/writes, buffers SDI audio bytes in a FIFO, drives DREQ flow control.
//  Feeds a downstream audio player via valid/ready.
//  Used as on-chip codec stand-in and as the bench responder for the MP3 player master.
// PARAMETERS
//  FIFO_DEPTH   2048  SDI byte FIFO depth, power of two.
//  DREQ_FREE    32    minimum free bytes for DREQ=1.
//  RST_HOLD     1000  CLK cycles DREQ held low after hard or soft reset.
//  SYNC_STAGES  2     synchronizer flops on XCS/XDCS/SCLK/SI/XRSET.
// PORTS
//  CLK         in   1   system clock, ≥8x SCLK.
//  RST         in   1   asynchronous active-high reset.
//  XRSET       in   1   codec hard reset, active low, async to CLK.
//  XCS         in   1   SCI select, active low.
//  XDCS        in   1   SDI select, active low.
//  SCLK        in   1   serial clock, mode 0; sample on rise.
//  SI          in   1   serial data in, MSB first.
//  SO          out  1   SCI read data.
//  DREQ        out  1   1 = ready to accept ≥DREQ_FREE bytes, or one SCI command.
//  aud_data    out  8   FIFO head byte.
//  aud_valid   out  1   FIFO non-empty.
//  aud_ready   in   1   downstream pop; a byte pops on aud_valid&aud_ready.
//  mode_reg    out  16  SCI register 0x00 (MODE).
//  vol_reg     out  16  SCI register 0x0B (VOL): [15:8] left, [7:0] right attenuation.
//  overflow    out  1   sticky: SDI byte dropped on full FIFO; cleared by reset only.
//  proto_err   out  1   one-CLK pulse on an illegal frame (see below).
// BEHAVIOUR
//  Reset (RST=1): SO=0, DREQ=0, aud_valid=0, mode_reg=16'h0800, vol_reg=0, overflow=0, proto_err=0.
//    Remaining 14 regs are 0; FIFO is empty; both shifters are idle. Hold counter loads RST_HOLD.
//  XRSET low (synced) acts as RST, except it takes effect synchronously.
//  All serial inputs pass through SYNC_STAGES flops. SCLK edges come from the synced previous/current pair.
//  SCI frame (XCS=0): 32 bits MSB first, {opcode[7:0], addr[7:0], data[15:0]}. Bit counter clears on XCS fall.
//   Opcode 8'h02 = write. On the 32nd rising edge, reg[addr[3:0]] <= data, visible the next CLK.
//   Opcode 8'h03 = read. After bit 16 is sampled, SO drives reg[addr[3:0]][15] and shifts on each SCLK fall.
//     SO returns to 0 when XCS rises.
//   Any other opcode: frame ignored, proto_err pulses after bit 8.
//   XCS rising before 32 bits: frame discarded, no write, proto_err pulse. Bits beyond 32 ignored.
//  SDI (XDCS=0, XCS=1): 8-bit shifter, MSB first. Each 8th rising edge pushes the byte.
//   A 16-bit master word therefore lands as two bytes, high byte first.
//   FIFO full at push: byte dropped, overflow<=1. XDCS rising mid-byte discards the partial byte.
//  XCS=0 and XDCS=0 together: SCI wins, SDI shifter frozen and cleared, proto_err pulses once per overlap.
//  Soft reset: a MODE write with data[2]=1 flushes the FIFO, clears the SDI shifter and reloads the hold counter.
//    mode_reg stores data with bit2 cleared. vol and other regs are kept.
//  DREQ = (hold counter==0) && (free ≥ DREQ_FREE) && !(SCI write in progress).
//    Registered, one CLK latency. Deassert is the master's job to honour; data still accepted until full.
//  FIFO: simultaneous push and pop on the same CLK are both performed, count unchanged, full/empty correct at wrap.
//    aud_data is valid the same cycle aud_valid=1 (first-word-fall-through).
//  Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; free = FIFO_DEPTH - count.
// STRUCTURE
//  Package vs_pkg: SCI_OP_WRITE=8'h02, SCI_OP_READ=8'h03, SCI_MODE=4'h0, SCI_VOL=4'hB,
//    SM_RESET_BIT=2, MODE_DEFAULT=16'h0800.
//  Sub-module vs_byte_fifo (FWFT sync FIFO, flush input, count output).
//  Top-level parts: synchronizers, SCI FSM IDLE→SHIFT→(WRITE|READ_OUT)→IDLE, SDI shifter, register file, DREQ logic.
// TESTING
//  RST pulse, then wait RST_HOLD+3 CLK -> DREQ=1, mode_reg=16'h0800, aud_valid=0.
//  SCI write 32'h020B2020 then SCI read 32'h030B0000 -> vol_reg=16'h2020, SO returns 16'h2020 on bits 16..31.
//  SDI words 16'hABCD,16'h1234 with aud_ready=1 -> aud_data sequence AB,CD,12,34.
//  Stream with aud_ready=0 -> DREQ falls when free<32. Fill FIFO_DEPTH+1 bytes -> overflow=1, first 2048 bytes intact.
//  SCI write 32'h02000804 -> FIFO empty, DREQ low RST_HOLD cycles, mode_reg=16'h0800.
//  XCS rises after 20 bits; XCS/XDCS overlap -> proto_err pulses, registers and FIFO unchanged.

Source files
------------

// File: rtl/vs_pkg.sv
// Shared constants and types for the VS1003B-style SPI responder.
package vs_pkg;

  localparam logic [7:0]  SCI_OP_WRITE = 8'h02;
  localparam logic [7:0]  SCI_OP_READ  = 8'h03;
  localparam logic [3:0]  SCI_MODE     = 4'h0;
  localparam logic [3:0]  SCI_VOL      = 4'hB;
  localparam int          SM_RESET_BIT = 2;
  localparam logic [15:0] MODE_DEFAULT = 16'h0800;

  typedef enum logic [2:0] {
    SCI_IDLE,
    SCI_SHIFT,
    SCI_WRITE,
    SCI_READ_OUT,
    SCI_DONE
  } sci_state_t;

endpackage

// File: rtl/vs_spi_responder_if.sv
// Serial link, audio stream and status signals between the MP3 master side
// and the codec responder.
interface vs_spi_responder_if;

  logic        xrset;
  logic        xcs;
  logic        xdcs;
  logic        sclk;
  logic        si;
  logic        so;
  logic        dreq;
  logic [7:0]  aud_data;
  logic        aud_valid;
  logic        aud_ready;
  logic [15:0] mode_reg;
  logic [15:0] vol_reg;
  logic        overflow;
  logic        proto_err;

  modport slave (
    input  xrset, xcs, xdcs, sclk, si, aud_ready,
    output so, dreq, aud_data, aud_valid, mode_reg, vol_reg, overflow, proto_err
  );

  modport master (
    output xrset, xcs, xdcs, sclk, si, aud_ready,
    input  so, dreq, aud_data, aud_valid, mode_reg, vol_reg, overflow, proto_err
  );

endinterface

// File: rtl/vs_byte_fifo.sv
// First-word-fall-through byte FIFO with flush. Pointers carry one extra
// wrap bit so full and empty are distinguishable when the indices match.
module vs_byte_fifo #(
  parameter int DEPTH = 2048
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [7:0]              push_data,
  input  logic                    pop,
  output logic [7:0]              pop_data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage array, written only when a byte is actually accepted
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Read/write pointers; a flush empties the FIFO without touching storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/vs_spi_responder.sv
// Codec-side end of the SCI/SDI serial link: register file over SCI,
// SDI byte buffering into a FIFO, and DREQ flow control.
module vs_spi_responder
  import vs_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2048,
  parameter int DREQ_FREE   = 32,
  parameter int RST_HOLD    = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  vs_spi_responder_if.slave  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = $clog2(RST_HOLD + 1);

  logic [4:0]  sync_q [SYNC_STAGES];
  logic        xrset_s, xcs_s, xdcs_s, sclk_s, si_s;
  logic        sclk_prev, overlap_prev;
  logic        sync_rst, sclk_rise, sclk_fall, overlap;

  sci_state_t  state, state_next;
  logic [5:0]  bit_cnt;
  logic [15:0] sci_sr, so_sr, wr_data;
  logic [7:0]  op_q;
  logic [3:0]  addr_q;
  logic        sci_err, latch_op, latch_addr, load_so, reg_we, soft_rst, write_busy;
  logic [15:0] regs [16];

  logic [6:0]  sdi_sr;
  logic [2:0]  sdi_cnt;
  logic        sdi_active, push;
  logic [7:0]  push_data;

  logic [CW-1:0] fifo_count, fifo_free;
  logic          fifo_empty, fifo_full;
  logic [HW-1:0] hold_cnt;
  logic          dreq_q, overflow_q, proto_err_q;

  // Synchronizer chain for every input coming from the master's clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 5'b11100;
    end else begin
      sync_q[0] <= {bus.xrset, bus.xcs, bus.xdcs, bus.sclk, bus.si};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {xrset_s, xcs_s, xdcs_s, sclk_s, si_s} = sync_q[SYNC_STAGES-1];
  assign sync_rst  = ~xrset_s;
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign overlap   = ~xcs_s & ~xdcs_s;

  // Previous-sample flops for SCLK edge and select-overlap detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev    <= 1'b0;
      overlap_prev <= 1'b0;
    end else begin
      sclk_prev    <= sclk_s;
      overlap_prev <= overlap;
    end
  end

  // SCI state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           state <= SCI_IDLE;
    else if (sync_rst) state <= SCI_IDLE;
    else               state <= state_next;
  end

  // SCI next-state: opcode checked after 8 bits, reads start after 16, writes commit at 32
  always_comb begin
    state_next = state;
    sci_err    = 1'b0;
    latch_op   = 1'b0;
    latch_addr = 1'b0;
    load_so    = 1'b0;
    reg_we     = 1'b0;
    case (state)
      SCI_IDLE: if (!xcs_s) state_next = SCI_SHIFT;
      SCI_SHIFT: begin
        if (xcs_s) begin
          sci_err    = 1'b1;
          state_next = SCI_IDLE;
        end else if (bit_cnt == 6'd8) begin
          latch_op = 1'b1;
          if (sci_sr[7:0] != SCI_OP_WRITE && sci_sr[7:0] != SCI_OP_READ) begin
            sci_err    = 1'b1;
            state_next = SCI_DONE;
          end
        end else if (bit_cnt == 6'd16) begin
          latch_addr = 1'b1;
          if (op_q == SCI_OP_READ) begin
            load_so    = 1'b1;
            state_next = SCI_READ_OUT;
          end
        end else if (bit_cnt == 6'd32) begin
          state_next = SCI_WRITE;
        end
      end
      SCI_WRITE: begin
        reg_we     = 1'b1;
        state_next = SCI_DONE;
      end
      SCI_READ_OUT: begin
        if (xcs_s) begin
          sci_err    = (bit_cnt != 6'd32);
          state_next = SCI_IDLE;
        end
      end
      SCI_DONE: if (xcs_s) state_next = SCI_IDLE;
      default:  state_next = SCI_IDLE;
    endcase
  end

  assign write_busy = (state == SCI_WRITE) ||
                      (state == SCI_SHIFT && bit_cnt > 6'd8 && op_q == SCI_OP_WRITE);
  assign soft_rst   = reg_we && (addr_q == SCI_MODE) && sci_sr[SM_RESET_BIT];

  // SCI datapath: bit counter, input shifter, latched opcode/address and SO shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst || sync_rst) begin
      bit_cnt <= '0;
      sci_sr  <= '0;
      so_sr   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
    end else begin
      if (state == SCI_IDLE) begin
        bit_cnt <= '0;
      end else if ((state == SCI_SHIFT || state == SCI_READ_OUT) && sclk_rise &&
                   bit_cnt != 6'd32) begin
        bit_cnt <= bit_cnt + 6'd1;
        sci_sr  <= {sci_sr[14:0], si_s};
      end
      if (latch_op)   op_q   <= sci_sr[7:0];
      if (latch_addr) addr_q <= sci_sr[3:0];
      if (load_so)
        so_sr <= regs[sci_sr[3:0]];
      else if (state == SCI_READ_OUT && sclk_fall && bit_cnt > 6'd16)
        so_sr <= {so_sr[14:0], 1'b0};
    end
  end

  always_comb begin
    wr_data = sci_sr;
    if (addr_q == SCI_MODE) wr_data[SM_RESET_BIT] = 1'b0;
  end

  // Register file; MODE never keeps its soft-reset bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst || sync_rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= (4'(i) == SCI_MODE) ? MODE_DEFAULT : 16'h0000;
    end else if (reg_we) begin
      regs[addr_q] <= wr_data;
    end
  end

  assign sdi_active = xcs_s & ~xdcs_s;
  assign push       = sdi_active & sclk_rise & (sdi_cnt == 3'd7);
  assign push_data  = {sdi_sr, si_s};

  // SDI byte shifter; partial bytes are thrown away whenever SDI is not selected alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdi_sr  <= '0;
      sdi_cnt <= '0;
    end else if (sync_rst || soft_rst || !sdi_active) begin
      sdi_sr  <= '0;
      sdi_cnt <= '0;
    end else if (sclk_rise) begin
      sdi_sr  <= push_data[6:0];
      sdi_cnt <= sdi_cnt + 3'd1;
    end
  end

  vs_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (sync_rst | soft_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.aud_ready),
    .pop_data  (bus.aud_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign fifo_free = CW'(FIFO_DEPTH) - fifo_count;

  // Reset hold counter, registered DREQ, sticky overflow and protocol error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst || sync_rst) begin
      hold_cnt    <= HW'(RST_HOLD);
      dreq_q      <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (soft_rst)             hold_cnt <= HW'(RST_HOLD);
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - HW'(1);
      dreq_q      <= (hold_cnt == '0) && (fifo_free >= CW'(DREQ_FREE)) && !write_busy;
      if (push && fifo_full) overflow_q <= 1'b1;
      proto_err_q <= sci_err | (overlap & ~overlap_prev);
    end
  end

  assign bus.so        = (state == SCI_READ_OUT) & so_sr[15];
  assign bus.dreq      = dreq_q;
  assign bus.aud_valid = ~fifo_empty;
  assign bus.mode_reg  = regs[SCI_MODE];
  assign bus.vol_reg   = regs[SCI_VOL];
  assign bus.overflow  = overflow_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_vs_spi_responder.sv
// Directed bench for vs_spi_responder: stimulus drives SCI/SDI frames and
// queues expected audio bytes; a negedge monitor pops and compares them.
module tb_vs_spi_responder;
  import vs_pkg::*;

  localparam int DEPTH = 128;
  localparam int FREE  = 32;
  localparam int HOLD  = 100;
  localparam int H     = 5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails = 0;
  int   err_pulses = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  vs_spi_responder_if bus();

  vs_spi_responder #(
    .FIFO_DEPTH  (DEPTH),
    .DREQ_FREE   (FREE),
    .RST_HOLD    (HOLD),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shifts out the top nbits of word MSB first (mode 0) and captures SO for bits 16..31
  task automatic applyStimulus(input logic [31:0] word, input int nbits, output logic [15:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.si = word[31-i];
      tick(H);
      if (i >= 16 && i < 32) rd[31-i] = bus.so;
      bus.sclk = 1'b1;
      tick(H);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic sciFrame(input logic [31:0] word, output logic [15:0] rd);
    bus.xcs = 1'b0;
    applyStimulus(word, 32, rd);
    tick(H);
    bus.xcs = 1'b1;
    tick(8);
  endtask

  task automatic sdiBits(input logic [15:0] data, input int nbits);
    logic [15:0] unused_rd;
    bus.xdcs = 1'b0;
    applyStimulus({data, 16'h0000}, nbits, unused_rd);
    tick(H);
    bus.xdcs = 1'b1;
    tick(6);
  endtask

  // Scoreboard monitor: counts proto_err pulses and checks every popped byte
  always @(negedge clk) begin
    if (bus.proto_err === 1'b1) err_pulses++;
    if (bus.aud_valid === 1'b1 && bus.aud_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL aud_unexpected: got 0x%0h, expected no byte", bus.aud_data);
      end else begin
        checkOutput("aud_data", {24'h0, bus.aud_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rd;
    logic [7:0]  b;
    int          base;
    int          cnt;

    bus.xrset = 1'b1;
    bus.xcs = 1'b1;
    bus.xdcs = 1'b1;
    bus.sclk = 1'b0;
    bus.si = 1'b0;
    bus.aud_ready = 1'b0;
    rst = 1'b1;
    tick(3);
    checkOutput("rst_so",        {31'h0, bus.so},        0);
    checkOutput("rst_dreq",      {31'h0, bus.dreq},      0);
    checkOutput("rst_aud_valid", {31'h0, bus.aud_valid}, 0);
    checkOutput("rst_mode",      {16'h0, bus.mode_reg},  32'h0800);
    checkOutput("rst_vol",       {16'h0, bus.vol_reg},   0);
    checkOutput("rst_overflow",  {31'h0, bus.overflow},  0);
    checkOutput("rst_proto_err", {31'h0, bus.proto_err}, 0);
    rst = 1'b0;

    tick(HOLD / 2);
    checkOutput("dreq_during_hold", {31'h0, bus.dreq}, 0);
    tick(HOLD / 2 + 3);
    checkOutput("dreq_after_hold", {31'h0, bus.dreq},      1);
    checkOutput("mode_after_hold", {16'h0, bus.mode_reg},  32'h0800);
    checkOutput("valid_after_hold", {31'h0, bus.aud_valid}, 0);

    $display("[TB] SCI write/read of VOL");
    sciFrame(32'h020B2020, rd);
    checkOutput("vol_write", {16'h0, bus.vol_reg}, 32'h2020);
    sciFrame(32'h030B0000, rd);
    checkOutput("vol_read_so", {16'h0, rd}, 32'h2020);
    sciFrame(32'h03000000, rd);
    checkOutput("mode_read_so", {16'h0, rd}, 32'h0800);
    checkOutput("no_proto_err_valid_frames", err_pulses, 0);

    $display("[TB] SDI words with aud_ready high");
    bus.aud_ready = 1'b1;
    exp_q.push_back(8'hAB);
    exp_q.push_back(8'hCD);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    sdiBits(16'hABCD, 16);
    sdiBits(16'h1234, 16);
    tick(10);
    checkOutput("sdi_all_popped", exp_q.size(), 0);

    $display("[TB] fill FIFO with aud_ready low");
    bus.aud_ready = 1'b0;
    tick(2);
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'(i * 7 + 3);
      if (i < DEPTH) exp_q.push_back(b);
      sdiBits({b, 8'h00}, 8);
      if (i == DEPTH - FREE - 1) checkOutput("dreq_at_free_32", {31'h0, bus.dreq}, 1);
      if (i == DEPTH - FREE)     checkOutput("dreq_at_free_31", {31'h0, bus.dreq}, 0);
      if (i == DEPTH - 1)        checkOutput("overflow_at_full", {31'h0, bus.overflow}, 0);
    end
    checkOutput("overflow_set", {31'h0, bus.overflow}, 1);
    bus.aud_ready = 1'b1;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 2 * DEPTH + 20) begin
      tick(1);
      cnt++;
    end
    tick(3);
    checkOutput("fill_drained", exp_q.size(), 0);
    checkOutput("fill_valid_low", {31'h0, bus.aud_valid}, 0);
    checkOutput("overflow_sticky", {31'h0, bus.overflow}, 1);

    $display("[TB] soft reset via MODE write");
    bus.aud_ready = 1'b0;
    sdiBits(16'h1122, 16);
    checkOutput("pre_soft_valid", {31'h0, bus.aud_valid}, 1);
    bus.xcs = 1'b0;
    applyStimulus(32'h02000804, 32, rd);
    tick(H);
    bus.xcs = 1'b1;
    cnt = 2 * H;
    checkOutput("soft_fifo_flushed", {31'h0, bus.aud_valid}, 0);
    checkOutput("soft_mode", {16'h0, bus.mode_reg}, 32'h0800);
    checkOutput("soft_vol_kept", {16'h0, bus.vol_reg}, 32'h2020);
    while (bus.dreq !== 1'b1 && cnt < HOLD + 50) begin
      tick(1);
      cnt++;
    end
    checkOutput("soft_dreq_low_window", {31'h0, (cnt >= HOLD + 2 && cnt <= HOLD + 10)}, 1);
    bus.aud_ready = 1'b1;

    $display("[TB] truncated SCI write");
    base = err_pulses;
    bus.xcs = 1'b0;
    applyStimulus(32'h020B1111, 20, rd);
    tick(H);
    bus.xcs = 1'b1;
    tick(8);
    checkOutput("trunc_proto_err", err_pulses - base, 1);
    checkOutput("trunc_vol_kept", {16'h0, bus.vol_reg}, 32'h2020);

    $display("[TB] illegal opcode");
    base = err_pulses;
    sciFrame(32'h550B3333, rd);
    checkOutput("badop_proto_err", err_pulses - base, 1);
    checkOutput("badop_vol_kept", {16'h0, bus.vol_reg}, 32'h2020);

    $display("[TB] XCS/XDCS overlap");
    base = err_pulses;
    bus.xdcs = 1'b0;
    applyStimulus(32'hF0000000, 3, rd);
    bus.xcs = 1'b0;
    tick(3);
    applyStimulus(32'h030B0000, 32, rd);
    tick(H);
    bus.xcs = 1'b1;
    tick(H);
    bus.xdcs = 1'b1;
    tick(8);
    checkOutput("overlap_proto_err", err_pulses - base, 1);
    checkOutput("overlap_read_so", {16'h0, rd}, 32'h2020);
    checkOutput("overlap_fifo_empty", {31'h0, bus.aud_valid}, 0);
    checkOutput("overlap_vol_kept", {16'h0, bus.vol_reg}, 32'h2020);
    checkOutput("overlap_mode_kept", {16'h0, bus.mode_reg}, 32'h0800);

    tick(5);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
